// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter, req/done run control, registered ALU
// flags and a hardware call/return stack feeding instr_ROM.
// Optional feature macro: STACK_CHECK_EN (stack overflow/underflow detection
// with sticky stk_err; without it the stack wraps circularly).
module prog_sequencer #(
  parameter int D          = 12,
  parameter int OFF_W      = 8,
  parameter int DEPTH      = 4,
  parameter int START_ADDR = 0,
  parameter int HALT_ADDR  = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt_en,
  input  logic             reljump_en,
  input  logic             absjump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [D-1:0]     target,
  input  logic [OFF_W-1:0] offset,
  input  logic             flag_en,
  input  logic             sc_clr,
  input  logic             sc_i,
  input  logic             zero_i,
  input  logic             pari_i,
  output logic [D-1:0]     prog_ctr,
  output logic             sc_q,
  output logic             zero_q,
  output logic             pari_q,
  output logic             running,
  output logic             done,
  output logic             stk_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [D-1:0]     stk_q [DEPTH];
  logic [D-1:0]     stk_d [DEPTH];
  logic             sc_d, zero_d, pari_d;
  logic             fault;
  logic [D-1:0]     pc_inc;
  logic [D-1:0]     off_ext;
  logic [IDX_W-1:0] push_idx, pop_idx;

`ifdef STACK_CHECK_EN
  logic             stk_err_q, stk_err_d;
  assign stk_err = stk_err_q;
`else
  assign stk_err = 1'b0;
`endif

  assign prog_ctr = pc_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

  // Next-state, next-PC, stack and flag computation
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    stk_d    = stk_q;
    fault    = 1'b0;
    pc_inc   = pc_q + D'(1);
    off_ext  = D'($signed(offset));
    push_idx = IDX_W'(sp_q);
    pop_idx  = IDX_W'(sp_q - SP_W'(1));
`ifdef STACK_CHECK_EN
    stk_err_d = stk_err_q;
`endif

    sc_d   = sc_clr ? 1'b0 : (flag_en ? sc_i : sc_q);
    zero_d = flag_en ? zero_i : zero_q;
    pari_d = flag_en ? pari_i : pari_q;

    case (state_q)
      IDLE: begin
        pc_d = D'(START_ADDR);
        if (req) state_d = RUN;
      end
      RUN: begin
        if (ret_en) begin
`ifdef STACK_CHECK_EN
          if (sp_q == '0) begin
            stk_err_d = 1'b1;
            fault     = 1'b1;
          end else begin
`else
          begin
`endif
            pc_d = stk_q[pop_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end else if (call_en) begin
`ifdef STACK_CHECK_EN
          if (sp_q == SP_W'(DEPTH)) begin
            stk_err_d = 1'b1;
            fault     = 1'b1;
          end else begin
`else
          begin
`endif
            stk_d[push_idx] = pc_inc;
            sp_d            = sp_q + SP_W'(1);
            pc_d            = target;
          end
        end else if (absjump_en) begin
          pc_d = target;
        end else if (reljump_en) begin
          pc_d = pc_q + off_ext;
        end else begin
          pc_d = pc_inc;
        end
        // Halting on the computed next PC lets DONE coincide with HALT_ADDR load
        if (halt_en || fault || (pc_d == D'(HALT_ADDR))) state_d = DONE;
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
          pc_d    = D'(START_ADDR);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = D'(START_ADDR);
      end
    endcase
  end

  // State, PC, stack and flag registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= D'(START_ADDR);
      sp_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      sc_q    <= 1'b0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
`ifdef STACK_CHECK_EN
      stk_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      stk_q   <= stk_d;
      sc_q    <= sc_d;
      zero_q  <= zero_d;
      pari_q  <= pari_d;
`ifdef STACK_CHECK_EN
      stk_err_q <= stk_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (default parameters).
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, halt_en, reljump_en, absjump_en, call_en, ret_en;
  logic [11:0] target;
  logic [7:0]  offset;
  logic        flag_en, sc_clr, sc_i, zero_i, pari_i;
  logic [11:0] prog_ctr;
  logic        sc_q, zero_q, pari_q, running, done, stk_err;

  int checks   = 0;
  int failures = 0;

  prog_sequencer #(
    .D(12), .OFF_W(8), .DEPTH(4), .START_ADDR(0), .HALT_ADDR(128)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .halt_en(halt_en),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en),
    .ret_en(ret_en), .target(target), .offset(offset), .flag_en(flag_en),
    .sc_clr(sc_clr), .sc_i(sc_i), .zero_i(zero_i), .pari_i(pari_i),
    .prog_ctr(prog_ctr), .sc_q(sc_q), .zero_q(zero_q), .pari_q(pari_q),
    .running(running), .done(done), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    halt_en = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0;
    target = '0; offset = '0;
  endtask

  initial begin
    reset = 0; req = 0; clr_ctl();
    flag_en = 0; sc_clr = 0; sc_i = 0; zero_i = 0; pari_i = 0;
    #12;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_stk_err", stk_err, 0);
    chk("rst_flags", {sc_q, zero_q, pari_q}, 0);
    @(negedge clk); reset = 1;
    step();
    chk("idle_pc", prog_ctr, 0);

    // 1: straight-line run to HALT_ADDR
    req = 1;
    step();
    chk("t1_running", running, 1);
    chk("t1_first_pc", prog_ctr, 0);
    req = 0;
    for (int i = 1; i < 128; i++) begin
      step();
      chk("t1_pc", prog_ctr, i);
      if (i == 127) chk("t1_done_before_halt", done, 0);
    end
    step();
    chk("t1_halt_pc", prog_ctr, 128);
    chk("t1_done", done, 1);
    chk("t1_not_running", running, 0);
    req = 1;
    step();
    chk("t1_done_hold", done, 1);
    chk("t1_pc_frozen", prog_ctr, 128);
    req = 0;
    step();
    chk("t1_idle_done", done, 0);
    chk("t1_idle_pc", prog_ctr, 0);

    // 2: relative and absolute jumps
    req = 1;
    step();
    req = 0;
    for (int i = 0; i < 10; i++) step();
    chk("t2_pc10", prog_ctr, 10);
    reljump_en = 1; offset = 8'hFD;
    step();
    chk("t2_rel_neg", prog_ctr, 7);
    clr_ctl(); absjump_en = 1; target = 12'd40;
    step();
    chk("t2_abs", prog_ctr, 40);
    clr_ctl(); absjump_en = 1; reljump_en = 1; offset = 8'hFD; target = 12'd60;
    step();
    chk("t2_abs_over_rel", prog_ctr, 60);
    clr_ctl(); absjump_en = 1; target = 12'd4095;
    step();
    chk("t2_abs_max", prog_ctr, 4095);
    clr_ctl();
    step();
    chk("t2_wrap", prog_ctr, 0);
    chk("t2_still_running", running, 1);

    // 3: call/return and nested LIFO order
    absjump_en = 1; target = 12'd5;
    step();
    chk("t3_pc5", prog_ctr, 5);
    clr_ctl(); call_en = 1; target = 12'd100;
    step();
    chk("t3_call", prog_ctr, 100);
    clr_ctl(); ret_en = 1;
    step();
    chk("t3_ret", prog_ctr, 6);
    clr_ctl();
    for (int i = 0; i < 4; i++) begin
      call_en = 1; target = 12'(20 + 10 * i);
      step();
      chk("t3_nest_call", prog_ctr, 20 + 10 * i);
    end
    clr_ctl(); ret_en = 1;
    step(); chk("t3_ret1", prog_ctr, 51 - 10);
    step(); chk("t3_ret2", prog_ctr, 31);
    step(); chk("t3_ret3", prog_ctr, 21);
    step(); chk("t3_ret4", prog_ctr, 7);
    clr_ctl();

    // 5: flags (pc runs 8..11 meanwhile)
    flag_en = 1; sc_clr = 1; sc_i = 1; zero_i = 1; pari_i = 1;
    step();
    chk("t5_sc_clr_wins", sc_q, 0);
    chk("t5_zero_load", zero_q, 1);
    chk("t5_pari_load", pari_q, 1);
    flag_en = 0; sc_clr = 0; sc_i = 1; zero_i = 0; pari_i = 0;
    step();
    chk("t5_hold", {sc_q, zero_q, pari_q}, 3'b011);
    flag_en = 1;
    step();
    chk("t5_reload", {sc_q, zero_q, pari_q}, 3'b100);
    flag_en = 0; sc_clr = 1;
    step();
    chk("t5_sc_clr_only", {sc_q, zero_q, pari_q}, 3'b000);
    sc_clr = 0;
    chk("t5_pc", prog_ctr, 11);

    // 4: DEPTH+1 nested calls
    for (int i = 0; i < 4; i++) begin
      call_en = 1; target = 12'(20 + 10 * i);
      step();
    end
    chk("t4_pc_full", prog_ctr, 50);
    call_en = 1; target = 12'd60;
    step();
    clr_ctl();
`ifdef STACK_CHECK_EN
    chk("t4_stk_err", stk_err, 1);
    chk("t4_done", done, 1);
    chk("t4_pc_frozen", prog_ctr, 50);
    step();
    chk("t4_err_sticky", stk_err, 1);
`else
    chk("t4_stk_err", stk_err, 0);
    chk("t4_running", running, 1);
    chk("t4_pc", prog_ctr, 60);
    step();
    chk("t4_continue", prog_ctr, 61);
`endif

    // 6: asynchronous reset mid-run
    reset = 0; #2; reset = 1;
    step();
    chk("t6_idle", running, 0);
    req = 1;
    step();
    req = 0;
    for (int i = 0; i < 57; i++) step();
    chk("t6_pc57", prog_ctr, 57);
    #2 reset = 0;
    #1;
    chk("t6_async_pc", prog_ctr, 0);
    chk("t6_async_running", running, 0);
    chk("t6_async_err", stk_err, 0);
    @(negedge clk); reset = 1; req = 1;
    step();
    chk("t6_restart_pc", prog_ctr, 0);
    chk("t6_restart_running", running, 1);
    req = 0;
    step();
    chk("t6_pc1", prog_ctr, 1);

    // explicit halt instruction
    halt_en = 1;
    step();
    clr_ctl();
    chk("halt_done", done, 1);
    chk("halt_not_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
